fetch_queue: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the instruction memory and downstream of branch resolution.
- Owns the fetch PC and drives it to the instruction memory's combinational read port.
- Captures each returned word with its PC into a small FIFO and presents entries to decode over a valid/ready handshake.
- Supports redirect/flush from branch/jump resolution and a halt input.

---
 rtl/fetch_queue_if.sv | 23 ++
 rtl/fetch_queue.sv | 198 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Decode-side handshake bundle for fetch_queue.
// master: the fetch queue, which presents the head entry.
// slave:  the decode stage, which accepts it with outReady.
interface fetch_queue_if;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInst;
  logic [31:0] outPc;

  modport master (
    output outValid,
    output outInst,
    output outPc,
    input  outReady
  );

  modport slave (
    input  outValid,
    input  outInst,
    input  outPc,
    output outReady
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a small PC/instruction FIFO.
// The fetch PC register drives the instruction memory read port directly.
// Each returned word is written into the queue together with its PC.
// Decode reads the head entry over a valid/ready handshake.
// Redirect flushes the queue and reloads the PC. Halt freezes fetch while
// the queue keeps draining.
// Head outputs are registered. A word fetched into an empty queue appears
// one cycle later, and no path runs from imemInst to the outputs.
// Optional feature: define FETCH_STALL_COUNT_EN to add the stallCount output.
// It counts the cycles in which fetch is blocked by decode backpressure.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [31:0]   imemPc,
  input  logic [31:0]   imemInst,
  input  logic          halt,
  input  logic          redirect,
  input  logic [31:0]   redirectTarget,
  fetch_queue_if.master deq,
  output logic          alignErr
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [31:0]   stallCount
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Architectural state
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [31:0]      mem_inst_q [DEPTH];
  logic [31:0]      mem_inst_d [DEPTH];
  logic [31:0]      mem_pc_q   [DEPTH];
  logic [31:0]      mem_pc_d   [DEPTH];

  // Registered outputs
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_inst_q, out_inst_d;
  logic [31:0]      out_pc_q, out_pc_d;
  logic             align_err_q, align_err_d;

  // Per-cycle handshake decisions
  logic             pop_s;
  logic             push_s;
  logic             full_s;

  // Decide pop/push for this cycle; the registered outValid means pop never
  // fires on an empty queue and outValid never depends on outReady.
  always_comb begin
    pop_s  = out_valid_q & deq.outReady;
    full_s = (count_q == DEPTH_C);
    push_s = ~halt & ~redirect & (~full_s | pop_s);
  end

  // Next-state for PC, pointers, count and storage; redirect overrides all.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    align_err_d = 1'b0;
    mem_inst_d  = mem_inst_q;
    mem_pc_d    = mem_pc_q;

    if (redirect) begin
      // The fetch in this cycle is dropped. A same-cycle pop still counts
      // as taken by decode, but the queue empties either way.
      count_d     = CNT_ZERO;
      head_d      = PTR_ZERO;
      tail_d      = PTR_ZERO;
      fetch_pc_d  = {redirectTarget[31:2], 2'b00};
      align_err_d = |redirectTarget[1:0];
    end else begin
      if (push_s) begin
        mem_inst_d[tail_q] = imemInst;
        mem_pc_d[tail_q]   = fetch_pc_q;
        tail_d             = tail_q + PTR_ONE;
        fetch_pc_d         = fetch_pc_q + 32'd4;  // wraps modulo 2^32
      end else begin
        tail_d     = tail_q;
        fetch_pc_d = fetch_pc_q;
      end

      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Next head-entry outputs. Reading from the next-state storage keeps the
  // one-cycle fill latency. The old values are held while the queue is empty.
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    if (count_d != CNT_ZERO) begin
      out_valid_d = 1'b1;
      out_inst_d  = mem_inst_d[head_d];
      out_pc_d    = mem_pc_d[head_d];
    end else begin
      out_valid_d = 1'b0;
      out_inst_d  = out_inst_q;
      out_pc_d    = out_pc_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q  <= RESET_PC;
      count_q     <= CNT_ZERO;
      head_q      <= PTR_ZERO;
      tail_q      <= PTR_ZERO;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0000_0000;
      out_pc_q    <= 32'h0000_0000;
      align_err_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      align_err_q <= align_err_d;
    end
  end

  // Queue storage, cleared on reset so the head outputs never show X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= 32'h0000_0000;
        mem_pc_q[i]   <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= mem_inst_d[i];
        mem_pc_q[i]   <= mem_pc_d[i];
      end
    end
  end

`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  // Count cycles where fetch wanted to run but the full queue was not popped.
  always_comb begin
    stall_count_d = stall_count_q;
    if (redirect) begin
      stall_count_d = 32'h0000_0000;
    end else if (~halt & full_s & ~pop_s) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Backpressure stall counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= 32'h0000_0000;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stallCount = stall_count_q;
`endif

  assign imemPc       = fetch_pc_q;
  assign deq.outValid = out_valid_q;
  assign deq.outInst  = out_inst_q;
  assign deq.outPc    = out_pc_q;
  assign alignErr     = align_err_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue.
// It runs a table of directed vectors, then random stimulus against a
// queue-based reference model, then hand-written wrap and stall sequences.
module tb_fetch_queue;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        align_err;
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  fetch_queue_if deq_if ();

  fetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imemPc         (imem_pc),
    .imemInst       (imem_inst),
    .halt           (halt),
    .redirect       (redirect),
    .redirectTarget (redirect_target),
    .deq            (deq_if),
    .alignErr       (align_err)
`ifdef FETCH_STALL_COUNT_EN
    ,
    .stallCount     (stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  assign imem_inst = mem_word(imem_pc);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_inst;
  logic        m_align;
  logic [31:0] m_stall;

  task automatic model_reset();
    mq.delete();
    m_pc        = RST_PC;
    m_last_pc   = 32'h0;
    m_last_inst = 32'h0;
    m_align     = 1'b0;
    m_stall     = 32'h0;
  endtask

  task automatic model_check();
    chk("rnd_valid", {31'h0, deq_if.outValid}, {31'h0, (mq.size() > 0)});
    chk("rnd_outPc", deq_if.outPc, m_last_pc);
    chk("rnd_outInst", deq_if.outInst, m_last_inst);
    chk("rnd_imemPc", imem_pc, m_pc);
    chk("rnd_alignErr", {31'h0, align_err}, {31'h0, m_align});
`ifdef FETCH_STALL_COUNT_EN
    chk("rnd_stallCount", stall_count, m_stall);
`endif
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit pop, full, push;
    pop  = (mq.size() > 0) && deq_if.outReady;
    full = (mq.size() == DEPTH);
    if (redirect) begin
      mq.delete();
      m_pc    = {redirect_target[31:2], 2'b00};
      m_align = |redirect_target[1:0];
      m_stall = 32'h0;
    end else begin
      m_align = 1'b0;
      if (!halt && full && !pop) m_stall = m_stall + 32'd1;
      push = !halt && (!full || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    if (mq.size() > 0) begin
      m_last_pc   = mq[0];
      m_last_inst = mem_word(mq[0]);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        halt;
    logic        redir;
    logic [31:0] tgt;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_imem;
    logic        e_align;
  } vec_t;

  vec_t vecs[15];

  task automatic do_reset();
    reset_n = 1'b0;
    halt = 1'b0; redirect = 1'b0; redirect_target = 32'h0; deq_if.outReady = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'h0, deq_if.outValid}, 32'h0);
    chk("rst_outPc", deq_if.outPc, 32'h0);
    chk("rst_outInst", deq_if.outInst, 32'h0);
    chk("rst_imemPc", imem_pc, RST_PC);
    chk("rst_alignErr", {31'h0, align_err}, 32'h0);
`ifdef FETCH_STALL_COUNT_EN
    chk("rst_stallCount", stall_count, 32'h0);
`endif
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      halt            = ($urandom_range(0, 5) == 0);
      redirect        = ($urandom_range(0, 15) == 0);
      deq_if.outReady = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0)
        redirect_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        redirect_target = $urandom;
      model_check();
      model_step();
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0040_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0000, 32'h0040_0004, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0000, 32'h0040_0008, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0000, 32'h0040_0008, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0000, 32'h0040_0008, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0004, 32'h0040_000C, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0008, 32'h0040_0010, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0040_0103, 1'b1, 1'b1, 32'h0040_000C, 32'h0040_0014, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0040_000C, 32'h0040_0100, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0100, 32'h0040_0104, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0104, 32'h0040_0108, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0104, 32'h0040_0108, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0040_0104, 32'h0040_0108, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0040_0104, 32'h0040_0108, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0108, 32'h0040_010C, 1'b0};

    do_reset();

    // Directed table: backpressure fill, drain, redirect while full with an
    // unaligned target, halt drain and resume.
    for (int i = 0; i < 15; i++) begin
      halt            = vecs[i].halt;
      redirect        = vecs[i].redir;
      redirect_target = vecs[i].tgt;
      deq_if.outReady = vecs[i].ready;
      chk($sformatf("vec%0d_valid", i), {31'h0, deq_if.outValid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("vec%0d_outPc", i), deq_if.outPc, vecs[i].e_pc);
      chk($sformatf("vec%0d_imemPc", i), imem_pc, vecs[i].e_imem);
      chk($sformatf("vec%0d_alignErr", i), {31'h0, align_err}, {31'h0, vecs[i].e_align});
      if (vecs[i].e_valid)
        chk($sformatf("vec%0d_outInst", i), deq_if.outInst, mem_word(vecs[i].e_pc));
      @(negedge clk);
    end

    // Random stimulus against the reference model.
    do_reset();
    run_random(1500);

    // Asynchronous reset in mid-stream: outputs clear without a clock edge.
    halt = 1'b0; redirect = 1'b0; deq_if.outReady = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, deq_if.outValid}, 32'h0);
    chk("async_rst_imemPc", imem_pc, RST_PC);
    chk("async_rst_outPc", deq_if.outPc, 32'h0);
    do_reset();
    run_random(1500);

    // Wrap around the top of the address space.
    halt = 1'b0; deq_if.outReady = 1'b1;
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    chk("wrap_imemPc0", imem_pc, 32'hFFFF_FFFC);
    chk("wrap_valid0", {31'h0, deq_if.outValid}, 32'h0);
    chk("wrap_align0", {31'h0, align_err}, 32'h0);
    @(negedge clk);
    chk("wrap_outPc1", deq_if.outPc, 32'hFFFF_FFFC);
    chk("wrap_imemPc1", imem_pc, 32'h0000_0000);
    @(negedge clk);
    chk("wrap_outPc2", deq_if.outPc, 32'h0000_0000);
    chk("wrap_valid2", {31'h0, deq_if.outValid}, 32'h1);
    deq_if.outReady = 1'b0;

    // Backpressure: one filling cycle, then five blocked cycles.
    repeat (6) @(negedge clk);
    chk("bp_outPc", deq_if.outPc, 32'h0000_0000);
    chk("bp_outInst", deq_if.outInst, mem_word(32'h0000_0000));
    chk("bp_imemPc", imem_pc, 32'h0000_0008);
`ifdef FETCH_STALL_COUNT_EN
    chk("bp_stallCount", stall_count, 32'd5);
`endif
    redirect = 1'b1; redirect_target = 32'h0040_0100;
    @(negedge clk);
    redirect = 1'b0;
    chk("bp_redir_valid", {31'h0, deq_if.outValid}, 32'h0);
    chk("bp_redir_imemPc", imem_pc, 32'h0040_0100);
    chk("bp_redir_align", {31'h0, align_err}, 32'h0);
`ifdef FETCH_STALL_COUNT_EN
    chk("bp_redir_stallCount", stall_count, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
